// File: rtl/sobel_frame_ctrl.sv
// Frame controller for the Sobel engine: launches a frame, forwards engine writes to the
// output memory, then streams the whole frame back out over valid/ready.
module sobel_frame_ctrl #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned IMAGE_ROW_SIZE    = 256,
  parameter int unsigned IMAGE_COLUMN_SIZE = 256,
  parameter int unsigned PIXEL_COUNT       = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE,
  parameter int unsigned DRAIN_CYCLES      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  wr_err_o,
  output logic                  eng_start_o,
  input  logic                  eng_finish_i,
  input  logic                  eng_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] eng_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_pixel_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  pix_valid_o,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_last_o,
  input  logic                  pix_ready_i
);

  localparam int unsigned CntW   = $clog2(PIXEL_COUNT + 1);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] PixMax  = CntW'(PIXEL_COUNT);
  localparam logic [CntW-1:0] PixLast = CntW'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDump, StDone} state_e;

  state_e                state_q, state_d;
  logic [DrainW-1:0]     drain_q, drain_d;
  logic                  fin_q;
  logic                  wr_err_q;
  logic [CntW-1:0]       rd_addr_q;
  logic [CntW-1:0]       pop_cnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic       fwd, pop, push, issue, fin_edge, start_acc;
  logic [2:0] credit;

  assign fwd       = (state_q == StRun) || (state_q == StDrain);
  assign fin_edge  = eng_finish_i && !fin_q;
  assign start_acc = (state_q == StIdle) && start_i;

  assign pix_valid_o = (count_q != 2'd0);
  assign pix_data_o  = pix_valid_o ? fifo_q[rd_ptr_q] : '0;
  assign pix_last_o  = pix_valid_o && (pop_cnt_q == PixLast);
  assign pop         = pix_valid_o && pix_ready_i;
  assign push        = inflight_q;

  // Credits cover buffered and in-flight reads so the 2-entry FIFO can never overrun.
  assign credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = (state_q == StDump) && (rd_addr_q < PixMax) && (credit < 3'd2);

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign eng_start_o = (state_q == StRun);
  assign wr_err_o    = wr_err_q;

  always_comb begin
    mem_wr_en_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (fwd) begin
      mem_wr_en_o = eng_wr_en_i;
      mem_addr_o  = eng_addr_i;
      mem_wdata_o = eng_pixel_i;
    end else if (state_q == StDump) begin
      // Once every address is issued, park on the last one instead of running past the frame.
      mem_addr_o = (rd_addr_q < PixMax) ? ADDR_WIDTH'(rd_addr_q) : ADDR_WIDTH'(PixLast);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun: begin
        if (fin_edge) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (drain_q == '0) state_d = StDump;
        else               drain_d = drain_q - DrainW'(1);
      end
      StDump:  if (pop && pix_last_o) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      drain_q    <= '0;
      fin_q      <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_addr_q  <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      fin_q      <= eng_finish_i;
      inflight_q <= issue;
      if (start_acc) wr_err_q <= 1'b0;
      if (eng_wr_en_i && !fwd) wr_err_q <= 1'b1;
      if (start_acc) begin
        rd_addr_q <= '0;
        pop_cnt_q <= '0;
        wr_ptr_q  <= 1'b0;
        rd_ptr_q  <= 1'b0;
        count_q   <= 2'd0;
      end else begin
        if (issue) rd_addr_q <= rd_addr_q + CntW'(1);
        if (push) begin
          fifo_q[wr_ptr_q] <= mem_rdata_i;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q  <= ~rd_ptr_q;
          pop_cnt_q <= pop_cnt_q + CntW'(1);
        end
        if (push && !pop)      count_q <= count_q + 2'd1;
        else if (!push && pop) count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level controller for the Sobel engine and its output memory. It takes a host start pulse and launches `sobel_exc`. While the engine runs, it routes the engine's write port onto the single output-memory port. After `finish` plus a drain window, it takes the port back and streams every output pixel, in address order, over a valid/ready interface. It replaces testbench-side address muxing, so a frame can be processed and read out without external sequencing.

## Interface
- `DATA_WIDTH`, default 8: pixel width.
- `ADDR_WIDTH`, default 16: output-memory address width.
- `PIXEL_COUNT`, default `IMAGE_ROW_SIZE*IMAGE_COLUMN_SIZE`: pixels dumped per frame (≥2, ≤2^ADDR_WIDTH).
- `DRAIN_CYCLES`, default 2: cycles after finish edge during which late engine writes are still forwarded.
- `clk_i` in, 1: single clock, all logic on the rising edge.
- `rst_i` in, 1: synchronous, active-high reset.
- `start_i` in, 1: frame request; accepted only in IDLE.
- `busy_o` out, 1: high in every state except IDLE.
- `done_o` out, 1: one-cycle pulse after the last pixel handshake.
- `wr_err_o` out, 1: sticky; an engine write arrived outside RUN/DRAIN.
- `eng_start_o` out, 1: to `sobel_exc.start_i`; held high throughout RUN.
- `eng_finish_i` in, 1: from `sobel_exc.finish_o`.
- `eng_wr_en_i` in, 1: engine write enable.
- `eng_addr_i` in, ADDR_WIDTH: engine write address.
- `eng_pixel_i` in, DATA_WIDTH: engine write data.
- `mem_wr_en_o` out, 1: output-memory write enable.
- `mem_addr_o` out, ADDR_WIDTH: output-memory address.
- `mem_wdata_o` out, DATA_WIDTH: output-memory write data.
- `mem_rdata_i` in, DATA_WIDTH: output-memory read data. Synchronous read: data appears 1 cycle after the address.
- `pix_valid_o` out, 1: stream valid.
- `pix_data_o` out, DATA_WIDTH: stream pixel.
- `pix_last_o` out, 1: qualifies pixel PIXEL_COUNT-1.
- `pix_ready_i` in, 1: stream ready.

## Operation
- States: IDLE → RUN → DRAIN → DUMP → DONE → IDLE.
- **IDLE.**
  - `start_i`=1 → RUN next cycle.
  - Accepting a start clears `wr_err_o`, the read counter and the skid buffer.
- **RUN.**
  - `eng_start_o`=1.
  - Memory port is combinationally forwarded: `mem_wr_en_o`=`eng_wr_en_i`, `mem_addr_o`=`eng_addr_i`, `mem_wdata_o`=`eng_pixel_i`.
  - Exit on the rising edge of `eng_finish_i`: current sample is 1 and the registered previous sample is 0.
  - A finish level already high on entry does not count.
  - The previous-sample register resets to 0.
- **DRAIN.**
  - `eng_start_o`=0; forwarding continues.
  - A down-counter loaded with DRAIN_CYCLES-1 reaches 0 → DUMP.
  - DRAIN lasts exactly DRAIN_CYCLES cycles.
- **DUMP.**
  - `mem_wr_en_o`=0; `mem_addr_o`=read counter `rd_addr` (starts at 0).
  - Reads are credit-controlled into a 2-entry skid FIFO. A read issues in a cycle when `rd_addr` < PIXEL_COUNT and (FIFO count + reads in flight − pop this cycle) < 2. Each issue increments `rd_addr`.
  - Returned data is pushed to the FIFO one cycle after its issue.
  - `pix_valid_o` = FIFO not empty; `pix_data_o` = FIFO head.
  - Pop on `pix_valid_o && pix_ready_i`.
  - A pop counter tracks handshakes. `pix_last_o` = `pix_valid_o` and pop counter == PIXEL_COUNT-1.
  - Handshake with `pix_last_o`=1 → DONE.
- **DONE.** `done_o`=1 for one cycle → IDLE.
- `start_i` outside IDLE is ignored; it is not queued.
- **Engine write outside RUN/DRAIN:** not forwarded (`mem_wr_en_o` stays 0 or keeps its DUMP value); `wr_err_o` sets next cycle.
- `pix_valid_o` obeys AXI-style rules. Once high, it and `pix_data_o` hold until the handshake, and data never depends on `pix_ready_i` combinationally.
- **Reset** (any state, including mid-DUMP):
  - State IDLE; FIFO, counters and in-flight flag cleared.
  - All outputs 0: `busy_o`, `done_o`, `wr_err_o`, `eng_start_o`, `mem_wr_en_o`, `mem_addr_o`, `mem_wdata_o`, `pix_valid_o`, `pix_data_o`, `pix_last_o`.

## Timing
- `start_i` sampled at edge N: `busy_o` and `eng_start_o` high from N+1.
- Finish edge sampled at edge F: DRAIN occupies F+1 … F+DRAIN_CYCLES, and DUMP begins at F+DRAIN_CYCLES+1.
- DUMP entry at edge D: address 0 is driven in cycle D; `pix_valid_o` rises at D+2 (first FIFO push at D+1 is visible after D+2).
- With `pix_ready_i` held 1: one pixel per cycle, no bubbles; last handshake at D+PIXEL_COUNT+1; `done_o` high the following cycle.
- Ready deasserted: at most 2 pixels buffered; reads stall; no overrun, no drop, no duplicate.
- Combinational paths exist only `eng_*` → `mem_*` in RUN/DRAIN. All other outputs are registered or derived from registered state.

## Test plan
1. **Basic frame.** PIXEL_COUNT=16, DRAIN_CYCLES=2; engine writes data=addr^8'hA5 to 0..15, then finish, with ready=1.
   - Expected: 16 pixels in order, A5, A4, …; `pix_last_o` only on the 16th; `done_o` one cycle; `busy_o` low after.
2. **Late write.** Engine write to address 15 issued 2 cycles after the finish edge.
   - Expected: forwarded, with dumped pixel 15 equal to that value.
   - Same write 3 cycles after the finish edge: not forwarded, `wr_err_o`=1.
3. **Backpressure.** Ready pattern 1,0,0,1,0,1… random.
   - Expected: exact 16-pixel sequence with no loss or duplication; data stable while valid && !ready; `mem_addr_o` never exceeds 15.
4. **Stale finish.** `eng_finish_i` held high from before `start_i`.
   - Expected: RUN persists until finish drops and rises again; no premature dump.
5. **Reset mid-DUMP.** `rst_i` pulse after 5 handshakes.
   - Expected: all outputs 0 the next cycle, IDLE; a new start completes a full 16-pixel frame from address 0.
6. **Start collision.** `start_i` pulsed during RUN and DUMP.
   - Expected: ignored; exactly one `done_o` per accepted start.
